// File: rtl/sram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_pkg
// Shared sizing for the 64x8 dual-port SRAM and the FIFO controller that sits in
// front of it. Imported by the controller, the SRAM model and benches so that
// every user agrees on data width, address width and depth.
//   DW         : data width (bits)
//   AW         : address width (bits)
//   DEPTH      : number of entries, always 2**AW
//   addr_t     : SRAM address / FIFO pointer type
//   data_t     : SRAM word type
//   count_t    : occupancy type, wide enough to hold 0..DEPTH
//   FULL_COUNT : occupancy value that means "full"
// -----------------------------------------------------------------------------
package sram_fifo_pkg;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;
  typedef logic [AW:0]   count_t;

  localparam count_t FULL_COUNT = count_t'(DEPTH);

endpackage

// File: rtl/sram.sv
// -----------------------------------------------------------------------------
// sram
// 64x8 dual-port synchronous SRAM with registered read data on both ports.
// A read and a write to the same address at the same edge return the old word.
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous active-high reset, clears the output registers
//   data_a/addr_a  : port A write data and address
//   we_a           : port A write enable
//   q_a            : port A registered read data
//   data_b/addr_b  : port B write data and address
//   we_b           : port B write enable
//   q_b            : port B registered read data
// -----------------------------------------------------------------------------
module sram
  import sram_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  data_t data_a,
  input  addr_t addr_a,
  input  logic  we_a,
  output data_t q_a,
  input  data_t data_b,
  input  addr_t addr_b,
  input  logic  we_b,
  output data_t q_b
);

  data_t mem [DEPTH];

  // Storage array: both ports may write; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= data_a;
    end
    if (we_b) begin
      mem[addr_b] <= data_b;
    end
  end

  // Registered read data for both ports, giving a one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
// Turns the 64x8 dual-port SRAM into a first-word-fall-through FIFO. Port A is
// the write port, port B is read-only and its registered q_b is the FIFO head.
// The controller hides the one-cycle read latency by always presenting the
// address of the next head on addr_b, and holds rd_valid low for one cycle
// when the new head is being written at the same edge.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-low reset
//   wr_valid   : producer has wr_data
//   wr_ready   : FIFO can accept a push (registered)
//   wr_data    : push data
//   rd_valid   : rd_data holds the valid head entry (registered)
//   rd_ready   : consumer accepts the head
//   rd_data    : head data, straight from ram_q_b
//   count      : occupancy, 0..DEPTH
//   ram_data_a : to SRAM data_a (equals wr_data)
//   ram_addr_a : to SRAM addr_a (write pointer)
//   ram_we_a   : to SRAM we_a (push)
//   ram_addr_b : to SRAM addr_b (next head address)
//   ram_we_b   : to SRAM we_b, tied low
//   ram_q_b    : from SRAM q_b
// -----------------------------------------------------------------------------
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic [DW-1:0] ram_data_a,
  output logic [AW-1:0] ram_addr_a,
  output logic          ram_we_a,
  output logic [AW-1:0] ram_addr_b,
  output logic          ram_we_b,
  input  logic [DW-1:0] ram_q_b
);

  addr_t  wr_ptr_q, wr_ptr_d;
  addr_t  rd_ptr_q, rd_ptr_d;
  count_t count_q, count_d;
  logic   rd_valid_q, rd_valid_d;
  logic   wr_ready_q, wr_ready_d;
  logic   push, pop;

  // Handshakes and next-state values. Reset is folded into push/pop so that
  // no SRAM write or pointer advance happens while reset is asserted. A full
  // FIFO refuses a push even if a pop happens at the same edge, because
  // wr_ready only reflects the registered occupancy. The head is only valid
  // after an edge if the entry it points at was not written at that edge,
  // since port B cannot see that word until the following edge.
  always_comb begin
    push = wr_valid && wr_ready_q && reset;
    pop  = rd_valid_q && rd_ready && reset;

    wr_ptr_d = push ? wr_ptr_q + addr_t'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + addr_t'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + count_t'(1);
    end else if (pop && !push) begin
      count_d = count_q - count_t'(1);
    end

    wr_ready_d = (count_d != FULL_COUNT);
    rd_valid_d = (count_d != '0) && !(push && (wr_ptr_q == rd_ptr_d));
  end

  // All controller state, with synchronous active-low reset. Reset leaves the
  // FIFO empty and ready; SRAM contents are simply abandoned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Port B is addressed with the pointer the head will have after this edge,
  // so q_b always holds the current head one edge later. While the consumer
  // stalls, the address is constant and rd_data stays put.
  assign ram_addr_b = rd_ptr_d;
  assign ram_we_b   = 1'b0;
  assign rd_data    = ram_q_b;

  assign ram_data_a = wr_data;
  assign ram_addr_a = wr_ptr_q;
  assign ram_we_a   = push;

  assign wr_ready = wr_ready_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
// Bench for sram_fifo_ctrl driving a real sram instance. A queue-based model
// of the FIFO records every accepted push together with the edge it happened
// on; a separate monitor compares the DUT against that model on every falling
// edge. Directed sequences are followed by randomized traffic and resets.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  logic          clk;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic [DW-1:0] ram_data_a;
  logic [AW-1:0] ram_addr_a;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_b;
  logic          ram_we_b;
  logic [DW-1:0] ram_q_b;
  logic [DW-1:0] ram_q_a;

  sram_fifo_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .count      (count),
    .ram_data_a (ram_data_a),
    .ram_addr_a (ram_addr_a),
    .ram_we_a   (ram_we_a),
    .ram_addr_b (ram_addr_b),
    .ram_we_b   (ram_we_b),
    .ram_q_b    (ram_q_b)
  );

  sram u_sram (
    .clk    (clk),
    .reset  (!reset),
    .data_a (ram_data_a),
    .addr_a (ram_addr_a),
    .we_a   (ram_we_a),
    .q_a    (ram_q_a),
    .data_b ('0),
    .addr_b (ram_addr_b),
    .we_b   (ram_we_b),
    .q_b    (ram_q_b)
  );

  // Clock generation, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] data;
    int            wrEdge;
  } entry_t;

  entry_t        modelQ[$];
  int            edgeNum    = 0;
  logic [AW-1:0] wrPtrM     = '0;
  logic [AW-1:0] rdPtrM     = '0;
  logic          modelValid = 1'b0;
  logic          armed      = 1'b0;
  int            checks     = 0;
  int            passes     = 0;

  // Compare one DUT value against the model and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge.
  task automatic applyStimulus(input logic rst, input logic wv,
                               input logic [DW-1:0] wd, input logic rr);
    @(posedge clk);
    #1;
    reset    = rst;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
  endtask

  // Reference model, updated at each rising edge from the inputs alone. A word
  // becomes visible as the head only once an edge has passed since it was
  // written; a full FIFO takes no push regardless of a simultaneous pop.
  always @(posedge clk) begin
    logic doPush;
    logic doPop;
    edgeNum++;
    if (!reset) begin
      modelQ.delete();
      wrPtrM = '0;
      rdPtrM = '0;
      armed  = 1'b1;
    end else begin
      doPush = wr_valid && (modelQ.size() != DEPTH);
      doPop  = rd_ready && modelValid;
      if (doPop) begin
        void'(modelQ.pop_front());
        rdPtrM = rdPtrM + 1'b1;
      end
      if (doPush) begin
        modelQ.push_back('{data: wr_data, wrEdge: edgeNum});
        wrPtrM = wrPtrM + 1'b1;
      end
    end
    modelValid = (modelQ.size() != 0) && (modelQ[0].wrEdge != edgeNum);
  end

  // Monitor: on every falling edge compare outputs with the model, and the
  // head data whenever the DUT presents a valid head.
  always @(negedge clk) begin
    logic [AW-1:0] expAddrB;
    logic          expPush;
    logic          expPop;
    if (armed) begin
      expPush  = reset && wr_valid && (modelQ.size() != DEPTH);
      expPop   = reset && rd_ready && modelValid;
      expAddrB = expPop ? rdPtrM + 1'b1 : rdPtrM;
      checkOutput("count", 32'(count), 32'(modelQ.size()));
      checkOutput("wr_ready", 32'(wr_ready), 32'(modelQ.size() != DEPTH));
      checkOutput("rd_valid", 32'(rd_valid), 32'(modelValid));
      checkOutput("ram_we_a", 32'(ram_we_a), 32'(expPush));
      checkOutput("ram_addr_a", 32'(ram_addr_a), 32'(wrPtrM));
      checkOutput("ram_addr_b", 32'(ram_addr_b), 32'(expAddrB));
      checkOutput("ram_we_b", 32'(ram_we_b), 32'(1'b0));
      if (expPush) begin
        checkOutput("ram_data_a", 32'(ram_data_a), 32'(wr_data));
      end
      if (modelValid && rd_valid) begin
        checkOutput("rd_data", 32'(rd_data), 32'(modelQ[0].data));
      end
    end
  end

  // Directed sequences followed by randomized traffic with occasional resets.
  initial begin
    reset    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    rd_ready = 1'b0;
    $display("[TB] reset with wr_valid high");
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    $display("[TB] single push into empty FIFO");
    applyStimulus(1'b1, 1'b1, 8'hA6, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    $display("[TB] fill to full and stall");
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
    end
    repeat (3) applyStimulus(1'b1, 1'b1, 8'h41, 1'b0);

    $display("[TB] streaming from full with wrap");
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h41 + i), 1'b1);
    end
    repeat (70) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    $display("[TB] pop and push with one entry");
    applyStimulus(1'b1, 1'b1, 8'hD5, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC6, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    $display("[TB] consumer stall while pushing");
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

    $display("[TB] randomized traffic");
    for (int phase = 0; phase < 4; phase++) begin
      int wrPct;
      int rdPct;
      case (phase)
        0:       begin wrPct = 85; rdPct = 30; end
        1:       begin wrPct = 30; rdPct = 85; end
        2:       begin wrPct = 50; rdPct = 50; end
        default: begin wrPct = 95; rdPct = 95; end
      endcase
      for (int i = 0; i < 1000; i++) begin
        logic rst;
        logic wv;
        logic rr;
        rst = ($urandom_range(0, 399) != 0);
        wv  = ($urandom_range(0, 99) < wrPct);
        rr  = ($urandom_range(0, 99) < rdPct);
        applyStimulus(rst, wv, 8'($urandom), rr);
      end
    end

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the 64x8 dual-port sram and turns it into a first-word-fall-through FIFO.
- SRAM port A is the write port; SRAM port B is the read-only port, and its registered q_b is the FIFO head.
- Handles the SRAM's 1-cycle registered read latency and the write-then-read visibility hazard.
- Exposes valid/ready push and pop interfaces to the producer and consumer.

Parameters:
- DW, 8, data width; matches sram data width.
- AW, 6, address width; matches sram address width.
- DEPTH, 64, entries; must equal 2**AW.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- wr_valid  input  1  producer has wr_data.
- wr_ready  output  1  FIFO can accept a push.
- wr_data  input  DW  push data.
- rd_valid  output  1  rd_data holds the valid head entry.
- rd_ready  input  1  consumer accepts the head.
- rd_data  output  DW  head data; combinational pass-through of ram_q_b.
- count  output  AW+1  occupancy, 0..DEPTH.
- ram_data_a  output  DW  to sram data_a; equals wr_data.
- ram_addr_a  output  AW  to sram addr_a; equals wr_ptr.
- ram_we_a  output  1  to sram we_a; equals push.
- ram_addr_b  output  AW  to sram addr_b.
- ram_we_b  output  1  to sram we_b; tied 0.
- ram_q_b  input  DW  from sram q_b.

Behaviour:
- Definitions:
  - push = wr_valid && wr_ready.
  - pop = rd_valid && rd_ready.
- Reset (reset==0 at a clk edge):
  - wr_ptr, rd_ptr, count and rd_valid all go to 0.
  - wr_ready goes to 1.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-operation discards all contents. SRAM contents are not cleared.
- Pointers:
  - wr_ptr increments on push; rd_ptr increments on pop.
  - Both wrap naturally modulo DEPTH (63 -> 0).
- Count:
  - Increments on push only, decrements on pop only.
  - Unchanged on both or neither.
- Status flags (registered):
  - wr_ready = (count_next != DEPTH).
  - Full blocks a push even when a pop occurs in the same cycle; there is no full-bypass.
- Read address (combinational):
  - ram_addr_b = pop ? rd_ptr+1 : rd_ptr.
  - Net effect: ram_q_b always reflects ram[rd_ptr] from the previous edge's read.
- Visibility hazard:
  - An entry written at edge T is read into q_b no earlier than edge T+1.
  - rd_valid_next = (count_next != 0) && !(push && wr_ptr == rd_ptr_next).
  - I.e. rd_valid is held low for one cycle whenever the new head is the entry being written this edge.
- Latencies:
  - Push into empty FIFO at edge T: rd_valid=1 after edge T+1 (2-cycle latency).
  - Pop with count>=2, no hazard: next head valid immediately after the pop edge, giving full 1/cycle throughput.
  - Pop with count==1 and a simultaneous push: rd_valid drops for one cycle, then rises.
- Empty: rd_valid=0, and a rd_ready assertion is ignored.
- Stability: while rd_valid && !rd_ready, rd_data is held stable.
  - Addr_b is constant, and port A never writes rd_ptr while that entry is occupied.
- Illegal condition: wr_valid while full is legal; it simply stalls.

Decomposition:
- Package sram_fifo_pkg:
  - Holds DW, AW and DEPTH localparams, plus typedef addr_t (logic [AW-1:0]) and data_t.
  - Shared with sram instances and benches.
- No sub-module: pointer, count and valid logic fits in one module (~150 lines).
- The bench instantiates sram_fifo_ctrl and the existing sram side by side.
  - Sram reset is driven by !reset from the bench.

Test Plan:
1. Reset low for 2 cycles, then high, with wr_valid=1 during reset -> count=0, rd_valid=0, wr_ready=1, no ram_we_a during reset.
2. Push 8'hA6 into empty FIFO at edge T -> ram_addr_a=0, ram_we_a=1; rd_valid=0 after T, then rd_valid=1 and rd_data=8'hA6 after T+1.
3. Push 8'h01..8'h40 (64 entries) with rd_ready=0 -> count=64, wr_ready=0; a 65th wr_valid is stalled, with ram_we_a=0.
4. From full, hold rd_ready=1 and wr_valid=1 -> pops 8'h01, 8'h02, ... one per cycle; pushes resume after wr_ready rises; wr_ptr wraps 63->0 and data order is preserved.
5. count==1 (head 8'hD5), pop and push 8'hC6 in the same cycle -> rd_valid=0 for exactly one cycle, then rd_data=8'hC6.
6. rd_valid=1 with rd_ready=0 for 5 cycles while pushing 3 entries -> rd_data held constant; count goes 1->4.
